// File: rtl/line_gen_multi.sv
// Random line generator: WIDTH-bit shift register fed by a density-weighted Galois LFSR,
// with an all-zero refill phase. Optional LFSR reseed ports via `LINE_GEN_SEED_LOAD_EN.
module line_gen_multi #(
   parameter int unsigned WIDTH      = 640,
   parameter logic [15:0] SEED       = 16'hACE1,
   parameter logic [15:0] TAPS       = 16'hB400,
   parameter int unsigned REFILL_CYC = 4
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             en_i,
   input  logic             step_i,
   input  logic             dir_i,
   input  logic [4:0]       density_i,
`ifdef LINE_GEN_SEED_LOAD_EN
   input  logic             seed_load_i,
   input  logic [15:0]      seed_i,
`endif
   output logic [WIDTH-1:0] line_o,
   output logic             rand_bit_o,
   output logic             valid_o,
   output logic             refill_o,
   output logic             busy_o,
   output logic [15:0]      refill_cnt_o
);

   localparam logic [15:0] SEED_DEFAULT = 16'hACE1;
   localparam logic [15:0] SEED_EFF     = (SEED == 16'h0) ? SEED_DEFAULT : SEED;
   localparam logic [7:0]  REFILL_LD    = 8'(REFILL_CYC);
   localparam bit          HAS_REFILL   = (REFILL_CYC != 0);

   typedef enum logic {
      ST_RUN,
      ST_REFILL
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [7:0]       r_busy_cnt;
   logic [15:0]      r_lfsr;
   logic [WIDTH-1:0] r_line;
   logic             r_rand_bit;
   logic             r_valid;
   logic             r_refill;
   logic [15:0]      r_refill_cnt;

   logic             w_accept;
   logic             w_line_zero;
   logic [4:0]       w_dens_sat;
   logic             w_bit;
   logic [15:0]      w_lfsr_adv;

   assign w_accept    = en_i & step_i & (r_state == ST_RUN);
   assign w_line_zero = (r_line == '0);
   assign w_dens_sat  = (density_i > 5'd16) ? 5'd16 : density_i;
   // Density 0 forces ones, 16 forces zeros; in between, P(1) = (16 - density) / 16.
   assign w_bit       = ({1'b0, r_lfsr[3:0]} >= w_dens_sat);
   assign w_lfsr_adv  = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : 16'h0000);

   // State register
   // NOTE: sequential state is always updated with <= so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   // NOTE: the default assignment first keeps this block free of inferred latches.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN: begin
            if (w_accept && w_line_zero && HAS_REFILL) begin
               w_state_nxt = ST_REFILL;
            end
         end
         ST_REFILL: begin
            if (r_busy_cnt <= 8'd1) begin
               w_state_nxt = ST_RUN;
            end
         end
         default: w_state_nxt = ST_RUN;
      endcase
   end

   // Output logic
   always_comb begin
      busy_o = (r_state == ST_REFILL);
   end

   // The busy countdown runs independently of en_i once a refill has started.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_busy_cnt <= 8'd0;
      end else if (w_accept && w_line_zero) begin
         r_busy_cnt <= REFILL_LD;
      end else if ((r_state == ST_REFILL) && (r_busy_cnt != 8'd0)) begin
         r_busy_cnt <= r_busy_cnt - 8'd1;
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_line       <= '1;
         r_rand_bit   <= 1'b0;
         r_valid      <= 1'b0;
         r_refill     <= 1'b0;
         r_refill_cnt <= 16'h0000;
         r_lfsr       <= SEED_EFF;
      end else begin
         r_valid  <= 1'b0;
         r_refill <= 1'b0;
         if (w_accept) begin
            r_valid <= 1'b1;
            if (w_line_zero) begin
               // Refill leaves the LFSR and the last inserted bit untouched.
               r_line   <= '1;
               r_refill <= 1'b1;
               if (r_refill_cnt != 16'hFFFF) begin
                  r_refill_cnt <= r_refill_cnt + 16'd1;
               end
            end else begin
               if (dir_i) begin
                  r_line <= {r_line[WIDTH-2:0], w_bit};
               end else begin
                  r_line <= {w_bit, r_line[WIDTH-1:1]};
               end
               r_rand_bit <= w_bit;
               r_lfsr     <= w_lfsr_adv;
            end
         end
`ifdef LINE_GEN_SEED_LOAD_EN
         // A reseed wins over a same-edge advance; that step already used the old state.
         if (seed_load_i) begin
            r_lfsr <= (seed_i == 16'h0000) ? SEED_DEFAULT : seed_i;
         end
`endif
      end
   end

   assign line_o       = r_line;
   assign rand_bit_o   = r_rand_bit;
   assign valid_o      = r_valid;
   assign refill_o     = r_refill;
   assign refill_cnt_o = r_refill_cnt;

endmodule

// File: tb/tb_line_gen_multi.sv
// Scoreboard bench for line_gen_multi (WIDTH=8): directed steps push expected results,
// a negedge monitor pops and compares on every valid_o pulse.
module tb_line_gen_multi;

   localparam int unsigned W  = 8;
   localparam int unsigned RC = 4;

   logic         clk_i = 1'b0;
   logic         reset_i = 1'b0;
   logic         en_i = 1'b0;
   logic         en0 = 1'b0;
   logic         step_i = 1'b0;
   logic         dir_i = 1'b0;
   logic [4:0]   density_i = 5'd0;
`ifdef LINE_GEN_SEED_LOAD_EN
   logic         seed_load_i = 1'b0;
   logic [15:0]  seed_i = 16'h0000;
`endif

   logic [W-1:0] line_o;
   logic         rand_bit_o, valid_o, refill_o, busy_o;
   logic [15:0]  refill_cnt_o;
   logic [W-1:0] line0;
   logic         rand0, valid0, refill0, busy0;
   logic [15:0]  cnt0;

   line_gen_multi #(.WIDTH(W), .SEED(16'hACE1), .TAPS(16'hB400), .REFILL_CYC(RC)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .step_i(step_i), .dir_i(dir_i),
      .density_i(density_i),
`ifdef LINE_GEN_SEED_LOAD_EN
      .seed_load_i(seed_load_i), .seed_i(seed_i),
`endif
      .line_o(line_o), .rand_bit_o(rand_bit_o), .valid_o(valid_o), .refill_o(refill_o),
      .busy_o(busy_o), .refill_cnt_o(refill_cnt_o)
   );

   line_gen_multi #(.WIDTH(W), .SEED(16'hACE1), .TAPS(16'hB400), .REFILL_CYC(0)) dut0 (
      .clk_i(clk_i), .reset_i(reset_i), .en_i(en0), .step_i(step_i), .dir_i(dir_i),
      .density_i(density_i),
`ifdef LINE_GEN_SEED_LOAD_EN
      .seed_load_i(1'b0), .seed_i(16'h0000),
`endif
      .line_o(line0), .rand_bit_o(rand0), .valid_o(valid0), .refill_o(refill0),
      .busy_o(busy0), .refill_cnt_o(cnt0)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [W-1:0] line;
      logic         rbit;
      logic         refill;
      logic [15:0]  cnt;
   } exp_t;

   exp_t q[$];
   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [W-1:0] m_line  = '1;
   logic [15:0]  m_lfsr  = 16'hACE1;
   logic         m_rand  = 1'b0;
   logic [15:0]  m_cnt   = 16'h0;
   logic         m_busy  = 1'b0;
   int           m_bcnt  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
   endfunction

   // Monitor: compares every valid_o pulse against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_i);
         if (reset_i && valid_o) begin
            if (q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_valid: got valid_o=1 expected no pending entry (t=%0t)", $time);
            end else begin
               e = q.pop_front();
               check("sb_line", line_o, e.line);
               check("sb_rand_bit", rand_bit_o, e.rbit);
               check("sb_refill", refill_o, e.refill);
               check("sb_refill_cnt", refill_cnt_o, e.cnt);
            end
         end else if (reset_i && refill_o) begin
            check("refill_without_valid", refill_o, 1'b0);
         end
      end
   end

   // Drive one cycle, update the model for the coming edge, then check handshake outputs.
   task automatic cycle(input logic st, input logic en, input logic dir, input logic [4:0] dens);
      logic acc;
      logic b;
      exp_t e;
      step_i    = st;
      en_i      = en;
      dir_i     = dir;
      density_i = dens;
      acc = en && st && !m_busy;
      if (acc) begin
         if (m_line == '0) begin
            m_line = '1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            e.refill = 1'b1;
            if (RC > 0) begin
               m_busy = 1'b1;
               m_bcnt = RC;
            end
         end else begin
            b = ({1'b0, m_lfsr[3:0]} >= ((dens > 5'd16) ? 5'd16 : dens));
            m_line = dir ? {m_line[W-2:0], b} : {b, m_line[W-1:1]};
            m_rand = b;
            m_lfsr = lfsr_next(m_lfsr);
            e.refill = 1'b0;
         end
         e.line = m_line;
         e.rbit = m_rand;
         e.cnt  = m_cnt;
         q.push_back(e);
      end else if (m_busy) begin
         if (m_bcnt <= 1) m_busy = 1'b0;
         else m_bcnt--;
      end
      @(posedge clk_i);
      #1;
      check("valid", valid_o, acc);
      check("busy", busy_o, m_busy);
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      #1;
      reset_i = 1'b0;
      step_i  = 1'b0;
      #1;
      check("rst_line", line_o, 8'hFF);
      check("rst_rand_bit", rand_bit_o, 1'b0);
      check("rst_valid", valid_o, 1'b0);
      check("rst_refill", refill_o, 1'b0);
      check("rst_busy", busy_o, 1'b0);
      check("rst_refill_cnt", refill_cnt_o, 16'h0);
      m_line = '1; m_lfsr = 16'hACE1; m_rand = 1'b0; m_cnt = 16'h0; m_busy = 1'b0; m_bcnt = 0;
      #2;
      reset_i = 1'b1;
      @(posedge clk_i);
      #1;
   endtask

`ifdef LINE_GEN_SEED_LOAD_EN
   task automatic load_seed(input logic [15:0] s);
      step_i      = 1'b0;
      seed_load_i = 1'b1;
      seed_i      = s;
      m_lfsr      = (s == 16'h0) ? 16'hACE1 : s;
      @(posedge clk_i);
      #1;
      seed_load_i = 1'b0;
      check("seed_lfsr", dut.r_lfsr, m_lfsr);
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [W-1:0] saved_line;
      logic [15:0]  saved_lfsr;

      #3;
      do_reset();

      // Density 0: every inserted bit is 1, line stays full while the LFSR advances.
      for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, 5'd0);
      check("d0_line", line_o, 8'hFF);
      check("d0_rand_bit", rand_bit_o, 1'b1);
      check("d0_lfsr", dut.r_lfsr, m_lfsr);

      do_reset();
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 5'd16);
      check("d16_right", line_o, 8'h1F);

      do_reset();
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1, 5'd16);
      check("d16_left", line_o, 8'hF8);

      do_reset();
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 5'd31);
      check("d31_right", line_o, 8'h1F);
      check("d31_rand_bit", rand_bit_o, 1'b0);

      // Drain to zero, refill, 4 ignored busy cycles, then shifting resumes.
      do_reset();
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, 5'd16);
      check("drain_zero", line_o, 8'h00);
      cycle(1'b1, 1'b1, 1'b0, 5'd16);
      check("refill_line", line_o, 8'hFF);
      check("refill_pulse", refill_o, 1'b1);
      check("refill_cnt1", refill_cnt_o, 16'd1);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 5'd16);
      check("busy_hold_line", line_o, 8'hFF);
      cycle(1'b1, 1'b1, 1'b0, 5'd16);
      check("resume_line", line_o, 8'h7F);

      // Second refill, then reset while busy.
      for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, 1'b0, 5'd16);
      cycle(1'b1, 1'b1, 1'b0, 5'd16);
      check("refill_cnt2", refill_cnt_o, 16'd2);
      cycle(1'b1, 1'b1, 1'b0, 5'd16);
      check("mid_refill_busy", busy_o, 1'b1);
      do_reset();

      // Enable low: steps lost, state frozen.
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, i[0], 5'd2);
      saved_line = m_line;
      saved_lfsr = m_lfsr;
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 5'd2);
      check("en0_line", line_o, saved_line);
      check("en0_lfsr", dut.r_lfsr, saved_lfsr);
      cycle(1'b1, 1'b1, 1'b0, 5'd2);
      check("en1_lfsr", dut.r_lfsr, lfsr_next(saved_lfsr));

      // REFILL_CYC=0 instance: refill without any busy phase.
      do_reset();
      en0 = 1'b1;
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 5'd16);
      check("rc0_zero", line0, 8'h00);
      cycle(1'b1, 1'b0, 1'b0, 5'd16);
      check("rc0_line", line0, 8'hFF);
      check("rc0_refill", refill0, 1'b1);
      check("rc0_valid", valid0, 1'b1);
      check("rc0_busy", busy0, 1'b0);
      check("rc0_cnt", cnt0, 16'd1);
      cycle(1'b1, 1'b0, 1'b0, 5'd16);
      check("rc0_resume", line0, 8'h7F);
      check("rc0_busy_after", busy0, 1'b0);
      check("rc0_rand", rand0, 1'b0);
      en0 = 1'b0;

      // Seed 16'hACE1, density 2: first bits 0,0,1,1 -> 7F,3F,9F,CF.
      do_reset();
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 5'd2);
      check("seq_line4", line_o, 8'hCF);
      for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 1'b0, 5'd2);
      check("seq_lfsr16", dut.r_lfsr, m_lfsr);

`ifdef LINE_GEN_SEED_LOAD_EN
      load_seed(16'h0000);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b1, 5'd2);
      check("reseed_lfsr", dut.r_lfsr, 16'h389C >> 1);
`endif

      step_i = 1'b0;
      en_i   = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      check("sb_drained", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
